// File: rtl/vector_complement_unit.sv
// Two-stage, valid/ready pipelined per-lane complement unit.
// Each lane can independently pass, ones-complement, negate or take the
// absolute value of its operand. Stage 1 selects and applies the inversion;
// stage 2 adds the +1 that turns an inversion into a twos-complement negate.
// Lanes never exchange carries, so every lane is a narrow independent
// inverter and incrementer.
module vector_complement_unit #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [1:0]               in_mode,
    input  logic [LANES-1:0]         in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_ovf
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ONES = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_ABS  = 2'b11
    } mode_e;

    // Most negative lane value: the one operand whose negation does not fit.
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    mode_e                   mode;

    // Stage 1 next-state values and registers.
    logic [LANES*WIDTH-1:0]  s1_data_d;
    logic [LANES-1:0]        s1_cin_d;
    logic [LANES-1:0]        s1_min_d;

    logic                    s1_valid;
    logic [LANES*WIDTH-1:0]  s1_data;
    logic [LANES-1:0]        s1_cin;
    logic [LANES-1:0]        s1_min;

    // Stage 2 next-state values; the stage 2 registers are the outputs.
    logic [LANES*WIDTH-1:0]  s2_data_d;
    logic [LANES-1:0]        s2_ovf_d;
    logic                    s2_valid;

    // Pipeline advance enables.
    logic                    s1_load;
    logic                    s2_load;

    assign mode = mode_e'(in_mode);

    // Stage 2 frees up whenever it is empty or its beat leaves this cycle;
    // stage 1 can then refill behind it. in_ready is exactly the stage 1
    // load condition, so a full pipeline with a draining output still
    // accepts a new beat every cycle.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign out_valid = s2_valid;

    // Stage 1 lane decode: choose inversion, carry-in and min-value detect.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves it unassigned and no latch is inferred.
        s1_data_d = '0;
        s1_cin_d  = '0;
        s1_min_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [WIDTH-1:0] lane;
            logic             neg_lane;
            logic             inv_lane;
            lane     = in_data[i*WIDTH +: WIDTH];
            // Negate in mode 10, and in mode 11 only for negative operands.
            neg_lane = in_mask[i] &&
                       ((mode == MODE_NEG) || ((mode == MODE_ABS) && lane[WIDTH-1]));
            inv_lane = neg_lane || (in_mask[i] && (mode == MODE_ONES));
            s1_data_d[i*WIDTH +: WIDTH] = inv_lane ? ~lane : lane;
            s1_cin_d[i] = neg_lane;
            s1_min_d[i] = (lane == MIN_VAL);
        end
    end

    // Stage 2 lane arithmetic: finish the negate and flag the unrepresentable case.
    always_comb begin
        s2_data_d = '0;
        s2_ovf_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            // Sum is truncated to the lane width: the carry out of one lane
            // never reaches its neighbour.
            s2_data_d[i*WIDTH +: WIDTH] = s1_data[i*WIDTH +: WIDTH]
                                        + {{(WIDTH-1){1'b0}}, s1_cin[i]};
            s2_ovf_d[i] = s1_cin[i] && s1_min[i];
        end
    end

    // Stage 1 register: captures a beat (with its mode and mask effects) on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset along with the valid bits so the
        // outputs read as zero during reset rather than as stale data.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_cin   <= '0;
            s1_min   <= '0;
        end else if (s1_load) begin
            // NOTE: non-blocking assignment for all state, so each register
            // samples pre-edge values regardless of block ordering.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= s1_data_d;
                s1_cin  <= s1_cin_d;
                s1_min  <= s1_min_d;
            end
        end
    end

    // Stage 2 register: drives the outputs and holds them while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_data_d;
                out_ovf  <= s2_ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_vector_complement_unit.sv
// Self-checking bench for vector_complement_unit (WIDTH=8, LANES=4).
// The driver pushes the reference-model result of every accepted beat into a
// queue; an independent monitor pops and compares on every output transfer
// and checks that stalled outputs hold still.
module tb_vector_complement_unit;

    localparam int W = 8;
    localparam int L = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [L*W-1:0]   in_data;
    logic [1:0]       in_mode;
    logic [L-1:0]     in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [L*W-1:0]   out_data;
    logic [L-1:0]     out_ovf;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [L+L*W-1:0] sb[$];
    logic             rand_ready_en = 1'b0;

    vector_complement_unit #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: lane-by-lane integer arithmetic modulo 2^W.
    function automatic logic [L+L*W-1:0] model(input logic [L*W-1:0] d,
                                               input logic [1:0] m,
                                               input logic [L-1:0] k);
        logic [L*W-1:0] r;
        logic [L-1:0]   o;
        int full, half, a, res;
        full = 1 << W;
        half = 1 << (W - 1);
        r = '0;
        o = '0;
        for (int i = 0; i < L; i++) begin
            a   = int'(d[i*W +: W]);
            res = a;
            if (k[i]) begin
                if (m == 2'd1) res = full - 1 - a;
                if (m == 2'd2 || (m == 2'd3 && a >= half)) begin
                    res  = (full - a) % full;
                    o[i] = (a == half);
                end
            end
            r[i*W +: W] = res[W-1:0];
        end
        return {o, r};
    endfunction

    function automatic logic [W-1:0] rnd_lane();
        case ($urandom % 6)
            0: return 8'h80;
            1: return 8'h00;
            2: return 8'h7F;
            3: return 8'hFF;
            4: return 8'h81;
            default: return W'($urandom);
        endcase
    endfunction

    // Present one beat from a negedge until it is accepted, then log its expected result.
    task automatic send(input logic [L*W-1:0] d, input logic [1:0] m, input logic [L-1:0] k);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_mask  = k;
        #1;
        while (!in_ready && waited <= 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited > 200) check("in_ready timeout", 64'd0, 64'd1);
        else sb.push_back(model(d, m, k));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Randomised downstream back-pressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready_en) out_ready = (($urandom % 3) != 0);
        end
    end

    // Monitor: compare every output transfer against the scoreboard head.
    initial begin
        logic             stalled;
        logic [L+L*W-1:0] held;
        logic [L+L*W-1:0] exp;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("stall hold", {out_valid, out_ovf, out_data}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected beat", {out_ovf, out_data}, 64'hDEAD);
                    end else begin
                        exp = sb.pop_front();
                        check("beat", {out_ovf, out_data}, exp);
                    end
                    stalled = 1'b0;
                end else if (out_valid) begin
                    stalled = 1'b1;
                    held    = {out_ovf, out_data};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_mask   = '0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, '0);
        check("reset out_ovf", out_ovf, '0);
        check("reset in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Negate with one min-value lane; latency of two cycles.
        send({8'h01, 8'h7F, 8'h80, 8'h00}, 2'b10, 4'b1111);
        #3;
        check("latency cycle1 out_valid", out_valid, 1'b0);
        @(negedge clk);
        #3;
        check("latency cycle2 out_valid", out_valid, 1'b1);
        check("negate data", out_data, {8'hFF, 8'h81, 8'h80, 8'h00});
        check("negate ovf", out_ovf, 4'b0010);
        repeat (3) @(negedge clk);

        // Absolute value with the min-value lane (lane 1) masked off.
        send({8'hF6, 8'h05, 8'h80, 8'hFF}, 2'b11, 4'b1101);
        @(negedge clk);
        #3;
        check("abs data", out_data, {8'h0A, 8'h05, 8'h80, 8'h01});
        check("abs ovf", out_ovf, 4'b0000);
        repeat (3) @(negedge clk);

        // Back-to-back ones-complement then pass.
        send(32'h5A5A5A5A, 2'b01, 4'b1111);
        send(32'h5A5A5A5A, 2'b00, 4'b1111);
        #3;
        check("b2b first", {out_valid, out_data}, {1'b1, 32'hA5A5A5A5});
        @(negedge clk);
        #3;
        check("b2b second", {out_valid, out_data}, {1'b1, 32'h5A5A5A5A});
        repeat (3) @(negedge clk);

        // Stall: continuous in_valid with out_ready low fills exactly two stages.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
            in_mode  = 2'($urandom);
            in_mask  = 4'($urandom);
            #1;
            if (in_ready) begin
                sb.push_back(model(in_data, in_mode, in_mask));
                acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stall accepted count", acc, 2);
        #1;
        check("stall in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        #2;
        check("drain beat 1 valid", out_valid, 1'b1);
        @(negedge clk);
        #3;
        check("drain beat 2 valid", out_valid, 1'b1);
        @(negedge clk);
        #3;
        check("drained", out_valid, 1'b0);
        @(negedge clk);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()}, 2'b10, 4'b1111);
        send({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()}, 2'b01, 4'b1111);
        #4;
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", out_valid, 1'b0);
        check("mid-reset out_data", out_data, '0);
        check("mid-reset in_ready", in_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send({8'h11, 8'h22, 8'h33, 8'h80}, 2'b10, 4'b1111);
        #3;
        check("no stale beat", out_valid, 1'b0);
        @(negedge clk);
        #3;
        check("first post-reset beat", {out_valid, out_ovf, out_data},
              {1'b1, 4'b0001, 8'hEF, 8'hDE, 8'hCD, 8'h80});
        repeat (3) @(negedge clk);

        // Random traffic with random back-pressure.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (($urandom % 4) == 0) @(negedge clk);
            else send({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()},
                      2'($urandom), 4'($urandom));
        end

        // Drain and confirm every expected beat was seen.
        rand_ready_en = 1'b0;
        out_ready     = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check("scoreboard empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
